// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms on a software start, waits for an immediate or
// level-crossing trigger on the registered ADC stream, captures a
// programmable number of samples into an internal buffer, then plays the
// buffer out on a valid/ready stream. abort_i returns to IDLE from anywhere.
//
// Optional build macro: ADC_CAP_DECIM_EN adds decim_i; after the trigger
// sample only every (decim_i+1)-th sample is stored.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start_i; outputs quiet
// ARM      | evaluating the trigger on adc_q every cycle
// CAPTURE  | writing adc_q into the buffer until len samples are stored
// READOUT  | presenting buffer samples on rd_* until the last handshake

module adc_capture_ctrl #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] adc_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        trig_mode_i,
   input  logic [DATA_W-1:0] trig_level_i,
   input  logic [ADDR_W:0]   len_i,
`ifdef ADC_CAP_DECIM_EN
   input  logic [7:0]        decim_i,
`endif
   output logic              busy_o,
   output logic              trig_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic              rd_last_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_READOUT = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L     = (ADDR_W+1)'(1);
   localparam logic [1:0]      MODE_RISE = 2'd1;
   localparam logic [1:0]      MODE_FALL = 2'd2;

   state_t                   state_q;
   state_t                   state_d;

   logic signed [DATA_W-1:0] adc_q;
   logic signed [DATA_W-1:0] adc_p;
   logic signed [DATA_W-1:0] level_s;

   logic [ADDR_W:0]          len_eff;
   logic [ADDR_W:0]          len_m1_q;
   logic [1:0]               mode_q;
   logic                     prev_vld_q;
   logic [ADDR_W:0]          wr_cnt_q;
   logic [ADDR_W:0]          rd_ptr_q;

   logic [DATA_W-1:0]        mem [DEPTH];

   logic                     start_acc;
   logic                     level_hit;
   logic                     trig_hit;
   logic                     store_en;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic                     rd_fetch;
   logic                     done_d;

   logic                     busy_q;
   logic                     done_q;
   logic                     rd_valid_q;
   logic                     rd_last_q;
   logic [DATA_W-1:0]        rd_data_q;

   assign level_s = trig_level_i;

`ifdef ADC_CAP_DECIM_EN
   logic [7:0] decim_q;
   logic [7:0] dec_cnt_q;

   assign store_en = (dec_cnt_q == 8'd0);

   // decimation factor latch and skip down-counter, reloaded on every store
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         decim_q   <= 8'd0;
         dec_cnt_q <= 8'd0;
      end else begin
         if (start_acc) begin
            decim_q <= decim_i;
         end
         if (trig_hit) begin
            dec_cnt_q <= decim_q;
         end else if (state_q == ST_CAPTURE) begin
            dec_cnt_q <= store_en ? decim_q : dec_cnt_q - 8'd1;
         end
      end
   end
`else
   assign store_en = 1'b1;
`endif

   // zero or oversize requests capture the whole buffer
   always_comb begin
      len_eff = len_i;
      if ((len_i == '0) || (len_i > DEPTH_L)) begin
         len_eff = DEPTH_L;
      end
   end

   // trigger condition for the latched mode; reserved mode fires immediately
   always_comb begin
      level_hit = 1'b1;
      case (mode_q)
         MODE_RISE: level_hit = prev_vld_q && (adc_p < level_s) && (adc_q >= level_s);
         MODE_FALL: level_hit = prev_vld_q && (adc_p > level_s) && (adc_q <= level_s);
         default:   level_hit = 1'b1;
      endcase
   end

   // next-state decode plus per-cycle strobes for the datapath
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      trig_hit  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      rd_fetch  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               start_acc = 1'b1;
               state_d   = ST_ARM;
            end
         end
         ST_ARM: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (level_hit) begin
               trig_hit = 1'b1;
               wr_en    = 1'b1;
               wr_addr  = '0;
               state_d  = (len_m1_q == '0) ? ST_READOUT : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (store_en) begin
               wr_en   = 1'b1;
               wr_addr = wr_cnt_q[ADDR_W-1:0];
               if (wr_cnt_q == len_m1_q) begin
                  state_d = ST_READOUT;
               end
            end
         end
         ST_READOUT: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (rd_valid_q && rd_ready_i && rd_last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (!rd_valid_q || rd_ready_i) begin
               rd_fetch = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state register with registered busy and done so both line up with state_o
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= done_d;
      end
   end

   // input pipeline, start-time latches and capture write counter
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         adc_q      <= '0;
         adc_p      <= '0;
         len_m1_q   <= '0;
         mode_q     <= 2'd0;
         prev_vld_q <= 1'b0;
         wr_cnt_q   <= '0;
      end else begin
         adc_q <= adc_i;
         adc_p <= adc_q;
         if (start_acc) begin
            len_m1_q   <= len_eff - ONE_L;
            mode_q     <= trig_mode_i;
            prev_vld_q <= 1'b0;
         end else if (state_q == ST_ARM) begin
            prev_vld_q <= 1'b1;
         end
         if (trig_hit) begin
            wr_cnt_q <= ONE_L;
         end else if ((state_q == ST_CAPTURE) && wr_en) begin
            wr_cnt_q <= wr_cnt_q + ONE_L;
         end
      end
   end

   // sample buffer; contents are not reset
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= adc_q;
      end
   end

   // registered buffer read feeding the output stream; holds while stalled
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else if ((state_q != ST_READOUT) || (state_d != ST_READOUT)) begin
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else if (rd_fetch) begin
         rd_data_q  <= mem[rd_ptr_q[ADDR_W-1:0]];
         rd_valid_q <= 1'b1;
         rd_last_q  <= (rd_ptr_q == len_m1_q);
         rd_ptr_q   <= rd_ptr_q + ONE_L;
      end
   end

   assign busy_o     = busy_q;
   assign trig_o     = trig_hit;
   assign done_o     = done_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_last_o  = rd_last_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: table of capture scenarios plus hand-written
// sequences for trigger guard, backpressure, abort and async reset.

module tb_adc_capture_ctrl;

   localparam int DATA_W = 12;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic [DATA_W-1:0] adc_i = '0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [1:0]        trig_mode_i = 2'd0;
   logic [DATA_W-1:0] trig_level_i = '0;
   logic [ADDR_W:0]   len_i = '0;
`ifdef ADC_CAP_DECIM_EN
   logic [7:0]        decim_i = 8'd0;
`endif
   logic              busy_o;
   logic              trig_o;
   logic              done_o;
   logic [DATA_W-1:0] rd_data_o;
   logic              rd_valid_o;
   logic              rd_ready_i = 1'b0;
   logic              rd_last_o;
   logic [1:0]        state_o;

   adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .adc_i        (adc_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .trig_mode_i  (trig_mode_i),
      .trig_level_i (trig_level_i),
      .len_i        (len_i),
`ifdef ADC_CAP_DECIM_EN
      .decim_i      (decim_i),
`endif
      .busy_o       (busy_o),
      .trig_o       (trig_o),
      .done_o       (done_o),
      .rd_data_o    (rd_data_o),
      .rd_valid_o   (rd_valid_o),
      .rd_ready_i   (rd_ready_i),
      .rd_last_o    (rd_last_o),
      .state_o      (state_o)
   );

   always #8 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0]        mode;
      logic [11:0]       level;
      logic [8:0]        len;
      logic [1:0]        wtype;
      logic [7:0]        decim;
      logic              rel;
      logic [8:0]        nexp;
      logic [7:0][11:0]  exp;
   } vec_t;

`ifdef ADC_CAP_DECIM_EN
   localparam int NV = 9;
`else
   localparam int NV = 8;
`endif

   vec_t        vecs [NV];
   int          errors = 0;
   int          checks = 0;
   int          wcnt = 0;
   int          wtype = 0;
   logic [11:0] wseq [32];
   logic [11:0] rd_buf [300];

   int          r_trigs, r_trig_cyc, r_nrd, r_lasts, r_lastidx;
   int          r_done_cyc, r_lastvld, r_timeout;
   logic [1:0]  r_arm_state;
   logic        r_arm_busy, r_end_busy, r_end_valid;
   logic [11:0] r_base;

   function automatic logic [11:0] wave_val(input int j);
      if (wtype == 0) return 12'(j);
      if (wtype == 1) return ((j % 8) < 4) ? 12'h111 : 12'h000;
      return (j < 32) ? wseq[j] : wseq[31];
   endfunction

   function automatic vec_t mk(input logic [1:0] mode, input logic [11:0] level,
                               input logic [8:0] len, input logic [1:0] wt,
                               input logic [7:0] dec, input logic rel, input logic [8:0] nexp,
                               input logic [11:0] e0, input logic [11:0] e1,
                               input logic [11:0] e2, input logic [11:0] e3,
                               input logic [11:0] e4, input logic [11:0] e5,
                               input logic [11:0] e6, input logic [11:0] e7);
      vec_t v;
      v.mode = mode; v.level = level; v.len = len; v.wtype = wt;
      v.decim = dec; v.rel = rel; v.nexp = nexp;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: new ADC sample shortly after the edge, return at the falling edge
   task automatic step();
      @(posedge clk_i);
      #2;
      adc_i = wave_val(wcnt);
      wcnt++;
      @(negedge clk_i);
   endtask

   // start a capture with rd_ready_i high and record what comes out
   task automatic capture(input logic [1:0] mode, input logic [11:0] level,
                          input logic [8:0] len, input int budget);
      bit fin;
      r_trigs = 0; r_trig_cyc = -1; r_nrd = 0; r_lasts = 0; r_lastidx = -1;
      r_done_cyc = -1; r_lastvld = -1; r_timeout = 0;
      r_end_busy = 1'b1; r_end_valid = 1'b1;
      trig_mode_i  = mode;
      trig_level_i = level;
      len_i        = len;
      r_base  = adc_i;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      len_i = 9'd2;
      trig_mode_i = 2'd0;
      r_arm_state = state_o;
      r_arm_busy  = busy_o;
      fin = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         if (c > 0) step();
         if (trig_o) begin
            r_trigs++;
            if (r_trig_cyc < 0) r_trig_cyc = c;
         end
         if (rd_valid_o) begin
            if (r_nrd < 300) rd_buf[r_nrd] = rd_data_o;
            if (rd_last_o) begin
               r_lasts++;
               r_lastidx = r_nrd;
            end
            r_nrd++;
            r_lastvld = c;
         end
         if (done_o) begin
            r_done_cyc  = c;
            r_end_busy  = busy_o;
            r_end_valid = rd_valid_o;
            fin = 1'b1;
         end
      end
      if (!fin) r_timeout = 1;
      step();
   endtask

   initial begin
      int          bad;
      int          n;
      int          hs;
      int          off;
      logic [11:0] expv;
      logic [11:0] b;
      logic [4:0]  pat;

      vecs[0] = mk(2'd0, 12'h000, 9'd4,   2'd0, 8'd0, 1'b1, 9'd4,   0, 0, 0, 0, 0, 0, 0, 0);
      vecs[1] = mk(2'd1, 12'h080, 9'd8,   2'd1, 8'd0, 1'b0, 9'd8,
                   12'h111, 12'h111, 12'h111, 12'h111, 12'h000, 12'h000, 12'h000, 12'h000);
      vecs[2] = mk(2'd2, 12'h080, 9'd6,   2'd1, 8'd0, 1'b0, 9'd6,
                   12'h000, 12'h000, 12'h000, 12'h000, 12'h111, 12'h111, 0, 0);
      vecs[3] = mk(2'd3, 12'h000, 9'd1,   2'd0, 8'd0, 1'b1, 9'd1,   0, 0, 0, 0, 0, 0, 0, 0);
      vecs[4] = mk(2'd0, 12'h000, 9'd0,   2'd0, 8'd0, 1'b1, 9'd256, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[5] = mk(2'd0, 12'h000, 9'd300, 2'd0, 8'd0, 1'b1, 9'd256, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mk(2'd0, 12'h000, 9'd256, 2'd0, 8'd0, 1'b1, 9'd256, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[7] = mk(2'd2, 12'h000, 9'd3,   2'd0, 8'd0, 1'b0, 9'd3,
                   12'h800, 12'h801, 12'h802, 0, 0, 0, 0, 0);
`ifdef ADC_CAP_DECIM_EN
      vecs[8] = mk(2'd0, 12'h000, 9'd4,   2'd0, 8'd2, 1'b1, 9'd4,   0, 0, 0, 0, 0, 0, 0, 0);
`endif
      for (int i = 0; i < 32; i++) wseq[i] = 12'h000;

      // reset values
      step();
      step();
      check("reset_outputs", {busy_o, trig_o, done_o, rd_data_o, rd_valid_o, rd_last_o, state_o}, 0);
      rstn_i = 1'b1;
      step();

      // table-driven captures
      for (int i = 0; i < NV; i++) begin
         wtype = int'(vecs[i].wtype);
         wcnt = 0;
         rd_ready_i = 1'b1;
`ifdef ADC_CAP_DECIM_EN
         decim_i = vecs[i].decim;
`endif
         step();
         step();
         capture(vecs[i].mode, vecs[i].level, vecs[i].len, 3000);
         check($sformatf("v%0d_timeout", i), r_timeout, 0);
         check($sformatf("v%0d_arm_state", i), {r_arm_busy, r_arm_state}, {1'b1, 2'd1});
         check($sformatf("v%0d_trig_count", i), r_trigs, 1);
         check($sformatf("v%0d_read_count", i), r_nrd, int'(vecs[i].nexp));
         for (int k = 0; k < int'(vecs[i].nexp) && k < r_nrd; k++) begin
            if (vecs[i].rel)
               expv = 12'(int'(r_base) + k * (int'(vecs[i].decim) + 1));
            else
               expv = vecs[i].exp[k];
            check($sformatf("v%0d_data%0d", i, k), rd_buf[k], expv);
         end
         check($sformatf("v%0d_last_count", i), r_lasts, 1);
         check($sformatf("v%0d_last_index", i), r_lastidx, int'(vecs[i].nexp) - 1);
         check($sformatf("v%0d_done_timing", i), r_done_cyc, r_lastvld + 1);
         check($sformatf("v%0d_end_idle", i), {r_end_busy, r_end_valid, state_o}, 0);
      end

      // falling trigger: first ARM sample would cross but must be ignored
      wtype = 2;
      wcnt = 0;
      wseq[0] = 12'h111; wseq[1] = 12'h111; wseq[2] = 12'h111; wseq[3] = 12'h010;
      for (int i = 4; i < 8; i++) wseq[i] = 12'h111;
      for (int i = 8; i < 32; i++) wseq[i] = 12'h000;
      repeat (4) step();
      capture(2'd2, 12'h080, 9'd2, 100);
      check("guard_timeout", r_timeout, 0);
      check("guard_trig_cycle", r_trig_cyc, 5);
      check("guard_trig_count", r_trigs, 1);
      check("guard_read_count", r_nrd, 2);
      check("guard_mem0", rd_buf[0], 12'h000);
      check("guard_mem1", rd_buf[1], 12'h000);

      // backpressure: ready pattern 1,0,0,1,1 from the first valid cycle
      wtype = 0;
      wcnt = 100;
      step();
      rd_ready_i  = 1'b0;
      trig_mode_i = 2'd0;
      len_i       = 9'd3;
      b = adc_i;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!rd_valid_o && n < 20) begin
         step();
         n++;
      end
      check("bp_valid_seen", rd_valid_o, 1);
      pat = 5'b11001;
      hs = 0;
      for (int i = 0; i < 5; i++) begin
         off = (i == 0) ? 0 : ((i == 4) ? 2 : 1);
         check($sformatf("bp_cycle%0d", i), {rd_valid_o, rd_last_o, rd_data_o},
               {1'b1, (i == 4), 12'(int'(b) + off)});
         rd_ready_i = pat[i];
         start_i = (i == 1);
         if (rd_valid_o && pat[i]) hs++;
         step();
      end
      start_i = 1'b0;
      check("bp_done", {done_o, rd_valid_o, state_o}, {1'b1, 1'b0, 2'd0});
      check("bp_handshakes", hs, 3);
      rd_ready_i = 1'b1;
      step();

      // abort in the middle of CAPTURE
      trig_mode_i = 2'd0;
      len_i = 9'd10;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      check("abort_in_capture", state_o, 2'd2);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_to_idle", {state_o, busy_o, rd_valid_o, trig_o, done_o}, 0);
      bad = 0;
      repeat (20) begin
         step();
         if (done_o || rd_valid_o || trig_o || busy_o) bad++;
      end
      check("abort_quiet", bad, 0);

      // start and abort together in IDLE
      start_i = 1'b1;
      abort_i = 1'b1;
      step();
      start_i = 1'b0;
      abort_i = 1'b0;
      bad = (state_o != 2'd0 || busy_o) ? 1 : 0;
      repeat (4) begin
         step();
         if (state_o != 2'd0 || busy_o || trig_o) bad++;
      end
      check("start_abort_idle", bad, 0);

      // asynchronous reset while a sample is presented
      rd_ready_i = 1'b0;
      trig_mode_i = 2'd0;
      len_i = 9'd8;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!rd_valid_o && n < 20) begin
         step();
         n++;
      end
      check("rst_valid_before", {rd_valid_o, state_o}, {1'b1, 2'd3});
      #3;
      rstn_i = 1'b0;
      #1;
      check("rst_async_outputs", {busy_o, trig_o, done_o, rd_data_o, rd_valid_o, rd_last_o, state_o}, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      rd_ready_i = 1'b1;
      step();
      check("rst_stays_idle", {state_o, busy_o}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
